// File: rtl/bus_dma_master_if.sv
// Master-side bus signals of the shared 2-master/5-slave bus.
// Only the DMA needs the master modport; the slave modport is the bus/arbiter side.
interface bus_dma_master_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          m_req;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_dout;
    logic          m_grant;
    logic [DW-1:0] m_din;

    modport master (
        output m_req,
        output m_wr,
        output m_addr,
        output m_dout,
        input  m_grant,
        input  m_din
    );

    modport slave (
        input  m_req,
        input  m_wr,
        input  m_addr,
        input  m_dout,
        output m_grant,
        output m_din
    );
endinterface

// File: rtl/bus_dma_master.sv
// Word-copy DMA initiator: copies len words from src to dst, one read then one write per word.
// Optional BUS_DMA_FILL_EN adds a fill mode that writes a latched constant instead of copying.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | m_req high, waiting for grant (also the retry point after grant loss)
// RD    | source address on the bus
// RDW   | read data returning, captured at end of cycle
// WR    | destination write of the captured (or fill) word
// DONE  | one-cycle completion pulse, bus released
module bus_dma_master #(
    parameter int AW = 16,
    parameter int DW = 32,
    parameter int LW = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
`ifdef BUS_DMA_FILL_EN
    input  logic                   fill,
    input  logic [DW-1:0]          fill_data,
`endif
    input  logic                   start,
    input  logic [AW-1:0]          src,
    input  logic [AW-1:0]          dst,
    input  logic [LW-1:0]          len,
    bus_dma_master_if.master       bus,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD,
        RDW,
        WR,
        DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] cur_src;
    logic [AW-1:0] cur_dst;
    logic [LW-1:0] remaining;
    logic          req_q;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] dout_q;
    logic          fill_mode;

`ifdef BUS_DMA_FILL_EN
    logic          fill_q;
    logic [DW-1:0] fill_data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_q      <= 1'b0;
            fill_data_q <= '0;
        end else if (state == IDLE && start) begin
            fill_q      <= fill;
            fill_data_q <= fill_data;
        end
    end

    assign fill_mode = fill_q;
`else
    assign fill_mode = 1'b0;
`endif

    // A write only counts while the grant is still held; losing it mid-WR abandons the word.
    assign bus.m_req  = req_q;
    assign bus.m_wr   = wr_q & bus.m_grant;
    assign bus.m_addr = addr_q;
    assign bus.m_dout = dout_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur_src   <= '0;
            cur_dst   <= '0;
            remaining <= '0;
            req_q     <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            wr_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            cur_src   <= src;
                            cur_dst   <= dst;
                            remaining <= len;
                            busy      <= 1'b1;
                            req_q     <= 1'b1;
                            state     <= REQ;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus.m_grant) begin
                        if (fill_mode) begin
`ifdef BUS_DMA_FILL_EN
                            dout_q <= fill_data_q;
`endif
                            addr_q <= cur_dst;
                            wr_q   <= 1'b1;
                            state  <= WR;
                        end else begin
                            addr_q <= cur_src;
                            state  <= RD;
                        end
                    end
                end
                RD: begin
                    state <= bus.m_grant ? RDW : REQ;
                end
                RDW: begin
                    if (bus.m_grant) begin
                        dout_q <= bus.m_din;
                        addr_q <= cur_dst;
                        wr_q   <= 1'b1;
                        state  <= WR;
                    end else begin
                        state <= REQ;
                    end
                end
                WR: begin
                    if (!bus.m_grant) begin
                        state <= REQ;
                    end else begin
                        cur_src   <= cur_src + AW'(1);
                        cur_dst   <= cur_dst + AW'(1);
                        remaining <= remaining - LW'(1);
                        if (remaining > LW'(1)) begin
                            if (fill_mode) begin
                                addr_q <= cur_dst + AW'(1);
                                wr_q   <= 1'b1;
                                state  <= WR;
                            end else begin
                                addr_q <= cur_src + AW'(1);
                                state  <= RD;
                            end
                        end else begin
                            req_q <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    req_q <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_dma_master.sv
// Directed bench for bus_dma_master with a word-addressed slave memory model.
// Define BUS_DMA_FILL_EN for both files to exercise the fill mode.
module tb_bus_dma_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] src;
    logic [15:0] dst;
    logic [7:0]  len;
    logic        busy;
    logic        done;
`ifdef BUS_DMA_FILL_EN
    logic        fill;
    logic [31:0] fill_data;
`endif

    bus_dma_master_if #(.AW(16), .DW(32)) bus ();

    bus_dma_master #(.AW(16), .DW(32), .LW(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
`ifdef BUS_DMA_FILL_EN
        .fill      (fill),
        .fill_data (fill_data),
`endif
        .start     (start),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:65535];

    // Slave: registered read data, write on granted write cycle.
    always @(posedge clk) begin
        if (bus.m_req && bus.m_grant && bus.m_wr)
            mem[bus.m_addr] <= bus.m_dout;
        bus.m_din <= mem[bus.m_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    int done_cyc;
    int req_cyc;
    int busy_cyc;
    int wr_cyc;
    logic [15:0] addr_at [0:63];
    logic        wr_at   [0:63];
    logic [31:0] dout_at [0:63];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Cycle 0 is the cycle start is high; cycle n is sampled 2 time units after edge n.
    task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l,
                            input int drop_lo, input int drop_hi, input int restart_at,
                            input int rst_at);
        int n;
        @(posedge clk); #1;
        start = 1'b1; src = s; dst = d; len = l;
        n = 0; done_cyc = -1; req_cyc = 0; busy_cyc = 0; wr_cyc = 0;
        while (n < 200 && done_cyc < 0) begin
            @(posedge clk); #1;
            n++;
            start = (n == restart_at);
            if (n == restart_at) begin
                src = 16'h1234; dst = 16'h3000; len = 8'd9;
            end
            bus.m_grant = !(n >= drop_lo && n <= drop_hi);
            #1;
            if (n < 64) begin
                addr_at[n] = bus.m_addr;
                wr_at[n]   = bus.m_wr;
                dout_at[n] = bus.m_dout;
            end
            if (bus.m_req) req_cyc++;
            if (busy) busy_cyc++;
            if (bus.m_wr) wr_cyc++;
            if (done) done_cyc = n;
            if (n == rst_at) begin
                reset_n = 1'b0;
                #1;
                chk("rst_req",  32'(bus.m_req),  32'd0);
                chk("rst_wr",   32'(bus.m_wr),   32'd0);
                chk("rst_addr", 32'(bus.m_addr), 32'd0);
                chk("rst_dout", bus.m_dout,      32'd0);
                chk("rst_busy", 32'(busy),       32'd0);
                chk("rst_done", 32'(done),       32'd0);
                n = 1000;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int idle_req;
        reset_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
        bus.m_grant = 1'b1;
`ifdef BUS_DMA_FILL_EN
        fill = 1'b0; fill_data = '0;
`endif
        mem[16'h0000] <= 32'd11; mem[16'h0001] <= 32'd22;
        mem[16'h0002] <= 32'd33; mem[16'h0003] <= 32'd44;
        mem[16'hFFFE] <= 32'hA0A0_0001; mem[16'hFFFF] <= 32'hA0A0_0002;
        mem[16'h3000] <= 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req",  32'(bus.m_req),  32'd0);
        chk("reset_busy", 32'(busy),       32'd0);
        chk("reset_addr", 32'(bus.m_addr), 32'd0);
        reset_n = 1'b1;

        // Uncontended copy of 4 words
        run_xfer(16'h0000, 16'h0100, 8'd4, 999, 999, -1, -1);
        chk("copy_done_cyc", 32'(done_cyc), 32'd14);
        chk("copy_busy_cyc", 32'(busy_cyc), 32'd13);
        chk("copy_req_cyc",  32'(req_cyc),  32'd13);
        chk("copy_wr_cyc",   32'(wr_cyc),   32'd4);
        chk("copy_rd_addr",  32'(addr_at[2]), 32'h0000);
        chk("copy_wr_addr",  32'(addr_at[4]), 32'h0100);
        chk("copy_wr_flag",  32'(wr_at[4]),   32'd1);
        chk("copy_wr_data",  dout_at[4],      32'd11);
        @(posedge clk); #1;
        chk("copy_m0100", mem[16'h0100], 32'd11);
        chk("copy_m0101", mem[16'h0101], 32'd22);
        chk("copy_m0102", mem[16'h0102], 32'd33);
        chk("copy_m0103", mem[16'h0103], 32'd44);

        // len == 0
        run_xfer(16'h0000, 16'h0700, 8'd0, 999, 999, -1, -1);
        chk("len0_done_cyc", 32'(done_cyc), 32'd1);
        chk("len0_req_cyc",  32'(req_cyc),  32'd0);
        chk("len0_busy_cyc", 32'(busy_cyc), 32'd0);

        // Grant dropped during the second word's RDW (cycles 6-7)
        run_xfer(16'h0000, 16'h0200, 8'd3, 6, 7, -1, -1);
        chk("gl_done_cyc", 32'(done_cyc), 32'd15);
        chk("gl_req_cyc",  32'(req_cyc),  32'd14);
        chk("gl_wr_cyc",   32'(wr_cyc),   32'd3);
        chk("gl_reread",   32'(addr_at[9]), 32'h0001);
        chk("gl_req_hold", 32'(addr_at[7] == addr_at[6]), 32'd1);
        @(posedge clk); #1;
        chk("gl_m0200", mem[16'h0200], 32'd11);
        chk("gl_m0201", mem[16'h0201], 32'd22);
        chk("gl_m0202", mem[16'h0202], 32'd33);

        // Address wrap with an ignored restart while busy
        run_xfer(16'hFFFE, 16'h0400, 8'd3, 999, 999, 5, -1);
        chk("wrap_done_cyc", 32'(done_cyc), 32'd11);
        chk("wrap_rd0", 32'(addr_at[2]), 32'hFFFE);
        chk("wrap_rd1", 32'(addr_at[5]), 32'hFFFF);
        chk("wrap_rd2", 32'(addr_at[8]), 32'h0000);
        @(posedge clk); #1;
        chk("wrap_m0400", mem[16'h0400], 32'hA0A0_0001);
        chk("wrap_m0401", mem[16'h0401], 32'hA0A0_0002);
        chk("wrap_m0402", mem[16'h0402], 32'd11);
        chk("wrap_m3000", mem[16'h3000], 32'd0);
        idle_req = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.m_req || busy) idle_req++;
        end
        chk("wrap_no_restart", 32'(idle_req), 32'd0);

        // Asynchronous reset mid-copy
        run_xfer(16'h0000, 16'h0500, 8'd4, 999, 999, -1, 5);
        chk("rst_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        idle_req = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.m_req || busy || done) idle_req++;
        end
        chk("rst_quiet", 32'(idle_req), 32'd0);

`ifdef BUS_DMA_FILL_EN
        fill = 1'b1; fill_data = 32'hDEADBEEF;
        run_xfer(16'h0000, 16'h0200, 8'd5, 999, 999, -1, -1);
        fill = 1'b0;
        chk("fill_done_cyc", 32'(done_cyc), 32'd7);
        chk("fill_wr_cyc",   32'(wr_cyc),   32'd5);
        chk("fill_req_cyc",  32'(req_cyc),  32'd6);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++)
            chk("fill_mem", mem[16'h0200 + 16'(i)], 32'hDEADBEEF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
